// File: rtl/rshift_pkg.sv
// rtl/rshift_pkg.sv - shared constants, clog2 and the stage record for rshift_pipe
package rshift_pkg;

    localparam int RSHIFT_WIDTH = 8;
    localparam int RSHIFT_SHW   = 8;

    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

    typedef struct packed {
        logic                    valid;
        logic [RSHIFT_WIDTH-1:0] data;
        logic [RSHIFT_SHW-1:0]   shamt;
        logic                    arith;
        logic                    sign;
        logic                    sticky;
    } rshift_stage_t;

endpackage

// File: rtl/rshift_stage.sv
// rtl/rshift_stage.sv - one pipeline register: conditional shift by 2**BIT, sticky accumulate, hold on stall
module rshift_stage
    import rshift_pkg::*;
#(
    parameter int WIDTH = RSHIFT_WIDTH,
    parameter int SHW   = RSHIFT_SHW,
    parameter int BIT   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ready,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             in_arith,
    input  logic             in_sign,
    input  logic             in_sticky,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_shamt,
    output logic             out_arith,
    output logic             out_sign,
    output logic             out_sticky
);

    localparam int               DIST      = 1 << BIT;
    localparam logic [WIDTH-1:0] ONES      = '1;
    localparam logic [WIDTH-1:0] FILL_MASK = ~(ONES >> DIST);
    localparam logic [WIDTH-1:0] LOW_MASK  = ~(ONES << DIST);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   shamt_q, shamt_d;
    logic             arith_q, arith_d;
    logic             sign_q, sign_d;
    logic             sticky_q, sticky_d;

    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        shamt_d  = shamt_q;
        arith_d  = arith_q;
        sign_d   = sign_q;
        sticky_d = sticky_q;
        if (ready) begin
            valid_d  = in_valid;
            shamt_d  = in_shamt;
            arith_d  = in_arith;
            sign_d   = in_sign;
            data_d   = in_data;
            sticky_d = in_sticky;
            if (in_shamt[BIT]) begin
                // fill comes from the original operand's sign, not the current MSB
                data_d   = (in_data >> DIST) | ((in_arith & in_sign) ? FILL_MASK : '0);
                sticky_d = in_sticky | (|(in_data & LOW_MASK));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            shamt_q  <= '0;
            arith_q  <= 1'b0;
            sign_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            shamt_q  <= shamt_d;
            arith_q  <= arith_d;
            sign_q   <= sign_d;
            sticky_q <= sticky_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_shamt  = shamt_q;
    assign out_arith  = arith_q;
    assign out_sign   = sign_q;
    assign out_sticky = sticky_q;

endmodule

// File: rtl/rshift_pipe.sv
// rtl/rshift_pipe.sv - pipelined logical/arithmetic right shifter with sticky flag and valid/ready flow control
module rshift_pipe
    import rshift_pkg::*;
#(
    parameter int WIDTH = RSHIFT_WIDTH,
    parameter int SHW   = RSHIFT_SHW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             in_arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sticky
);

    localparam int           L         = clog2(WIDTH);
    localparam logic [SHW:0] WIDTH_LIM = WIDTH[SHW:0];

    logic [L-1:0]     st_valid, st_arith, st_sign, st_sticky, stage_ready;
    logic [WIDTH-1:0] st_data  [L];
    logic [SHW-1:0]   st_shamt [L];

    logic             sat, fill;
    logic [WIDTH-1:0] s0_data;
    logic [SHW-1:0]   s0_shamt;
    logic             s0_sticky;

    // oversized shifts collapse to the fill pattern before entering S0
    always_comb begin
        sat       = ({1'b0, in_shamt} >= WIDTH_LIM);
        fill      = in_arith & in_data[WIDTH-1];
        s0_data   = sat ? {WIDTH{fill}} : in_data;
        s0_shamt  = sat ? '0 : in_shamt;
        s0_sticky = sat & (|in_data);
    end

    always_comb begin
        stage_ready        = '0;
        stage_ready[L-1]   = !st_valid[L-1] | out_ready;
        for (int k = L - 2; k >= 0; k--) begin
            stage_ready[k] = !st_valid[k] | stage_ready[k+1];
        end
    end

    for (genvar k = 0; k < L; k++) begin : g_stage
        logic             v_i, a_i, s_i, st_i;
        logic [WIDTH-1:0] d_i;
        logic [SHW-1:0]   sh_i;

        if (k == 0) begin : g_head
            assign v_i  = in_valid;
            assign d_i  = s0_data;
            assign sh_i = s0_shamt;
            assign a_i  = in_arith;
            assign s_i  = in_data[WIDTH-1];
            assign st_i = s0_sticky;
        end else begin : g_link
            assign v_i  = st_valid[k-1];
            assign d_i  = st_data[k-1];
            assign sh_i = st_shamt[k-1];
            assign a_i  = st_arith[k-1];
            assign s_i  = st_sign[k-1];
            assign st_i = st_sticky[k-1];
        end

        rshift_stage #(
            .WIDTH (WIDTH),
            .SHW   (SHW),
            .BIT   (L - 1 - k)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .ready      (stage_ready[k]),
            .in_valid   (v_i),
            .in_data    (d_i),
            .in_shamt   (sh_i),
            .in_arith   (a_i),
            .in_sign    (s_i),
            .in_sticky  (st_i),
            .out_valid  (st_valid[k]),
            .out_data   (st_data[k]),
            .out_shamt  (st_shamt[k]),
            .out_arith  (st_arith[k]),
            .out_sign   (st_sign[k]),
            .out_sticky (st_sticky[k])
        );
    end

    logic unused_tail;
    assign unused_tail = ^{st_shamt[L-1], st_arith[L-1], st_sign[L-1]};

    assign in_ready   = stage_ready[0];
    assign out_valid  = st_valid[L-1];
    assign out_data   = st_data[L-1];
    assign out_sticky = st_sticky[L-1];

endmodule

// File: tb/tb_rshift_pipe.sv
// tb/tb_rshift_pipe.sv - directed self-checking bench for rshift_pipe
module tb_rshift_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] in_shamt;
    logic       in_arith;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_sticky;

    int n_checks = 0;
    int n_fail   = 0;

    rshift_pipe #(.WIDTH(8), .SHW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_shamt   (in_shamt),
        .in_arith   (in_arith),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sticky (out_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_one(input logic [7:0] d, input logic [7:0] sh, input logic ar,
                           output logic [7:0] rd, output logic rs, output int lat);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d; in_shamt = sh; in_arith = ar;
        for (int i = 0; i < 10 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = out_data;
        rs = out_sticky;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_arith = 1'b0; out_ready = 1'b0;
        #3;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", out_data); end
        n_checks++; if (out_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_out_sticky got %b want 0", out_sticky); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_logical_sweep();
        logic [7:0] exp_tab [8];
        int nrx;
        exp_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        nrx = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                n_checks++;
                if (nrx >= 8) begin
                    n_fail++; $display("FAIL sweep_extra got result %h want none", out_data);
                end else begin
                    if (out_data !== exp_tab[nrx]) begin n_fail++; $display("FAIL sweep_data[%0d] got %h want %h", nrx, out_data, exp_tab[nrx]); end
                    n_checks++; if (out_sticky !== 1'b0) begin n_fail++; $display("FAIL sweep_sticky[%0d] got %b want 0", nrx, out_sticky); end
                    n_checks++; if (c !== nrx + 3) begin n_fail++; $display("FAIL sweep_timing[%0d] got cycle %0d want %0d", nrx, c, nrx + 3); end
                end
                nrx++;
            end
            if (c < 8) begin
                in_valid = 1'b1; in_data = 8'h80; in_shamt = 8'(7 - c); in_arith = 1'b0;
                n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sweep_in_ready[%0d] got %b want 1", c, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
        end
        n_checks++; if (nrx !== 8) begin n_fail++; $display("FAIL sweep_count got %0d want 8", nrx); end
    endtask

    task automatic test_directed();
        logic [7:0] td [10], tsh [10], texp [10];
        logic       tar [10], tst [10];
        logic [7:0] rd;
        logic       rs;
        int         lat;
        td   = '{8'ha5, 8'ha5, 8'ha5, 8'h80, 8'h25, 8'ha5, 8'h80, 8'h00, 8'h80, 8'hff};
        tsh  = '{8'h07, 8'h01, 8'h01, 8'h03, 8'h02, 8'h09, 8'hc8, 8'h08, 8'h04, 8'h00};
        tar  = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1};
        texp = '{8'h01, 8'h52, 8'hd2, 8'hf0, 8'h09, 8'h00, 8'hff, 8'h00, 8'h08, 8'hff};
        tst  = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0};
        for (int i = 0; i < 10; i++) begin
            run_one(td[i], tsh[i], tar[i], rd, rs, lat);
            n_checks++; if (rd !== texp[i]) begin n_fail++; $display("FAIL directed_data[%0d] %h>>%h got %h want %h", i, td[i], tsh[i], rd, texp[i]); end
            n_checks++; if (rs !== tst[i]) begin n_fail++; $display("FAIL directed_sticky[%0d] got %b want %b", i, rs, tst[i]); end
            n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL directed_latency[%0d] got %0d want 2", i, lat); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] bp_d [5], bp_e [5];
        logic       bp_s [5];
        logic [7:0] held;
        logic       held_v, held_s, pend;
        int         nacc, nrx;
        bp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        bp_e = '{8'h08, 8'h11, 8'h19, 8'h22, 8'h2a};
        bp_s = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
        nacc = 0; nrx = 0; pend = 1'b0; held_v = 1'b0; held = '0; held_s = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (pend) nacc++;
            out_ready = (c >= 8);
            if (nacc < 5) begin
                in_valid = 1'b1; in_data = bp_d[nacc]; in_shamt = 8'h01; in_arith = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c == 7) begin
                n_checks++; if (nacc !== 3) begin n_fail++; $display("FAIL bp_accepts got %0d want 3", nacc); end
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
            end
            if (out_valid && !out_ready) begin
                if (held_v) begin
                    n_checks++; if (out_data !== held || out_sticky !== held_s) begin n_fail++; $display("FAIL bp_stable got %h/%b want %h/%b", out_data, out_sticky, held, held_s); end
                end else begin
                    held = out_data; held_s = out_sticky; held_v = 1'b1;
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (nrx >= 5) begin
                    n_fail++; $display("FAIL bp_extra got %h want none", out_data);
                end else if (out_data !== bp_e[nrx] || out_sticky !== bp_s[nrx]) begin
                    n_fail++; $display("FAIL bp_order[%0d] got %h/%b want %h/%b", nrx, out_data, out_sticky, bp_e[nrx], bp_s[nrx]);
                end
                nrx++;
            end
            pend = in_valid && in_ready;
        end
        n_checks++; if (held !== 8'h08) begin n_fail++; $display("FAIL bp_held_value got %h want 08", held); end
        n_checks++; if (nrx !== 5) begin n_fail++; $display("FAIL bp_count got %0d want 5", nrx); end
        n_checks++; if (nacc !== 5) begin n_fail++; $display("FAIL bp_total_accepts got %0d want 5", nacc); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd;
        logic       rs;
        int         lat;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            in_valid = (c < 3); in_data = 8'h81; in_shamt = 8'h01; in_arith = 1'b0;
        end
        n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_prefill got valid %b ready %b want 1 0", out_valid, in_ready); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
        n_checks++; if (out_data !== 8'h00 || out_sticky !== 1'b0) begin n_fail++; $display("FAIL mid_out_clear got %h/%b want 00/0", out_data, out_sticky); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale[%0d] got valid %b data %h want no result", c, out_valid, out_data); end
        end
        run_one(8'h80, 8'h04, 1'b0, rd, rs, lat);
        n_checks++; if (rd !== 8'h08 || rs !== 1'b0) begin n_fail++; $display("FAIL mid_fresh got %h/%b want 08/0", rd, rs); end
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL mid_fresh_latency got %0d want 2", lat); end
    endtask

    initial begin
        test_reset();
        test_logical_sweep();
        test_directed();
        test_backpressure();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
